// File: rtl/ch1_sweep_pkg.sv
// Shared types and constants for the channel-1 frequency sweep sequencer.
package ch1_sweep_pkg;

    localparam int unsigned FREQ_W_DEF = 11;
    localparam int unsigned PER_W_DEF  = 3;

    localparam logic [10:0] FREQ_MAX        = 11'h7FF;
    localparam logic [3:0]  PER_ZERO_RELOAD = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        CALC,
        WRITE,
        RECHK
    } sweep_state_t;

endpackage

// File: rtl/ch1_sweep_calc.sv
// Sweep arithmetic: shadow +/- (shadow >> shift), one bit wider so the top bit flags overflow.
module ch1_sweep_calc #(
    parameter int unsigned FREQ_W = 11
) (
    input  logic [FREQ_W-1:0] shadow,
    input  logic [2:0]        shift,
    input  logic              negate,
    output logic [FREQ_W-1:0] new_freq,
    output logic              ovf
);

    logic [FREQ_W:0] delta;
    logic [FREQ_W:0] sum;

    // delta never exceeds shadow, so the subtract path cannot borrow into the top bit
    always_comb begin
        delta = {1'b0, shadow >> shift};
        sum   = negate ? ({1'b0, shadow} - delta) : ({1'b0, shadow} + delta);
    end

    assign new_freq = sum[FREQ_W-1:0];
    assign ovf      = sum[FREQ_W];

endmodule

// File: rtl/ch1_sweep_ctrl.sv
// Channel-1 frequency sweep sequencer (NR10). Optional DMG negate-clear quirk: CH1_SWEEP_NEG_QUIRK_EN.
module ch1_sweep_ctrl
    import ch1_sweep_pkg::*;
#(
    parameter int unsigned FREQ_W = FREQ_W_DEF,
    parameter int unsigned PER_W  = PER_W_DEF
) (
    input  logic              clk,
    input  logic              apu_reset,
    input  logic              sweep_tick,
    input  logic              ch1_restart,
    input  logic [PER_W-1:0]  sweep_period,
    input  logic              sweep_negate,
    input  logic [2:0]        sweep_shift,
    input  logic [FREQ_W-1:0] freq_in,
    output logic [FREQ_W-1:0] acc_d,
    output logic              freq_load,
    output logic              ch1_disable,
    output logic              sweep_en,
    output logic              busy
);

    // timer is one bit wider than the period so a zero period can reload as 2^PER_W
    localparam int unsigned     TMR_W       = PER_W + 1;
    localparam logic [TMR_W-1:0] ZERO_RELOAD = TMR_W'(1) << PER_W;

    sweep_state_t      state, state_nxt;
    logic [FREQ_W-1:0] shadow, shadow_nxt, acc_d_nxt, calc_new;
    logic [TMR_W-1:0]  timer, timer_nxt, period_reload;
    logic              sweep_en_nxt, freq_load_nxt, disable_nxt, calc_ovf;
    logic              period_nz, shift_nz;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
    logic              neg_used, neg_used_nxt, neg_prev;
`endif

    ch1_sweep_calc #(.FREQ_W(FREQ_W)) u_calc (
        .shadow   (shadow),
        .shift    (sweep_shift),
        .negate   (sweep_negate),
        .new_freq (calc_new),
        .ovf      (calc_ovf)
    );

    assign period_nz     = (sweep_period != '0);
    assign shift_nz      = (sweep_shift != 3'd0);
    assign period_reload = period_nz ? TMR_W'(sweep_period) : ZERO_RELOAD;

    // next-state and next-output decode
    always_comb begin
        state_nxt     = state;
        shadow_nxt    = shadow;
        timer_nxt     = timer;
        sweep_en_nxt  = sweep_en;
        acc_d_nxt     = acc_d;
        freq_load_nxt = 1'b0;
        disable_nxt   = 1'b0;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
        neg_used_nxt  = neg_used;
`endif
        unique case (state)
            IDLE: begin
                if (ch1_restart) begin
                    state_nxt = TRIG;
                end else if (sweep_tick) begin
                    if (timer <= TMR_W'(1)) begin
                        timer_nxt = period_reload;
                        if (sweep_en && period_nz) state_nxt = CALC;
                    end else begin
                        timer_nxt = timer - TMR_W'(1);
                    end
                end
            end
            TRIG: begin
                shadow_nxt   = freq_in;
                timer_nxt    = period_reload;
                sweep_en_nxt = period_nz || shift_nz;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
                neg_used_nxt = 1'b0;
`endif
                if (ch1_restart)   state_nxt = TRIG;
                else if (shift_nz) state_nxt = RECHK;
                else               state_nxt = IDLE;
            end
            CALC: begin
                if (ch1_restart) begin
                    state_nxt = TRIG;
                end else begin
`ifdef CH1_SWEEP_NEG_QUIRK_EN
                    if (sweep_negate) neg_used_nxt = 1'b1;
`endif
                    if (calc_ovf) begin
                        disable_nxt  = 1'b1;
                        sweep_en_nxt = 1'b0;
                        state_nxt    = IDLE;
                    end else begin
                        state_nxt = shift_nz ? WRITE : IDLE;
                    end
                end
            end
            WRITE: begin
                if (ch1_restart) begin
                    state_nxt = TRIG;
                end else begin
                    shadow_nxt    = calc_new;
                    acc_d_nxt     = calc_new;
                    freq_load_nxt = 1'b1;
                    state_nxt     = RECHK;
                end
            end
            RECHK: begin
                if (ch1_restart) begin
                    state_nxt = TRIG;
                end else begin
                    if (calc_ovf) begin
                        disable_nxt  = 1'b1;
                        sweep_en_nxt = 1'b0;
                    end
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef CH1_SWEEP_NEG_QUIRK_EN
        // leaving negate mode after a negated calculation kills the channel
        if (neg_prev && !sweep_negate && neg_used && sweep_en) begin
            disable_nxt  = 1'b1;
            sweep_en_nxt = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (apu_reset) begin
            state       <= IDLE;
            shadow      <= '0;
            timer       <= '0;
            sweep_en    <= 1'b0;
            acc_d       <= '0;
            freq_load   <= 1'b0;
            ch1_disable <= 1'b0;
            busy        <= 1'b0;
`ifdef CH1_SWEEP_NEG_QUIRK_EN
            neg_used    <= 1'b0;
            neg_prev    <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            shadow      <= shadow_nxt;
            timer       <= timer_nxt;
            sweep_en    <= sweep_en_nxt;
            acc_d       <= acc_d_nxt;
            freq_load   <= freq_load_nxt;
            ch1_disable <= disable_nxt;
            busy        <= (state_nxt != IDLE);
`ifdef CH1_SWEEP_NEG_QUIRK_EN
            neg_used    <= neg_used_nxt;
            neg_prev    <= sweep_negate;
`endif
        end
    end

endmodule

// File: tb/tb_ch1_sweep_ctrl.sv
// Bench for ch1_sweep_ctrl: directed scenarios plus randomized sweeps against an event-level model.
module tb_ch1_sweep_ctrl;

    localparam int unsigned FREQ_W = 11;
    localparam int unsigned PER_W  = 3;
    localparam int          LIMIT  = 2047;

    logic              clk = 1'b0;
    logic              apu_reset, sweep_tick, ch1_restart, sweep_negate;
    logic [PER_W-1:0]  sweep_period;
    logic [2:0]        sweep_shift;
    logic [FREQ_W-1:0] freq_in, acc_d;
    logic              freq_load, ch1_disable, sweep_en, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [31:0]       cyc;
        logic [FREQ_W-1:0] val;
    } load_ev_t;

    load_ev_t got_ld[$], exp_ld[$];
    int       got_dis[$], exp_dis[$];

    int m_shadow, m_timer;
    bit m_en;

    ch1_sweep_ctrl #(.FREQ_W(FREQ_W), .PER_W(PER_W)) dut (
        .clk          (clk),
        .apu_reset    (apu_reset),
        .sweep_tick   (sweep_tick),
        .ch1_restart  (ch1_restart),
        .sweep_period (sweep_period),
        .sweep_negate (sweep_negate),
        .sweep_shift  (sweep_shift),
        .freq_in      (freq_in),
        .acc_d        (acc_d),
        .freq_load    (freq_load),
        .ch1_disable  (ch1_disable),
        .sweep_en     (sweep_en),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // event monitor: stamps each strobe with the edge index that produced it
    always @(negedge clk) begin
        if (freq_load)   got_ld.push_back({32'(cyc), acc_d});
        if (ch1_disable) got_dis.push_back(cyc);
    end

    function automatic load_ev_t mk_ev(input int c, input int v);
        load_ev_t ev;
        ev.cyc = 32'(c);
        ev.val = FREQ_W'(v);
        return ev;
    endfunction

    function automatic load_ev_t ld_at(input int i);
        return (i < got_ld.size()) ? got_ld[i] : '1;
    endfunction

    function automatic int calc_new(input int sh, input int s, input bit neg);
        int d;
        d = sh >> s;
        return neg ? sh - d : sh + d;
    endfunction

    function automatic int reload_of(input int p);
        return (p == 0) ? 8 : p;
    endfunction

    // reference model: trigger / tick effects as event predictions
    task automatic mdl_restart(input int e);
        m_shadow = int'(freq_in);
        m_timer  = reload_of(int'(sweep_period));
        m_en     = (sweep_period != 0) || (sweep_shift != 0);
        if (sweep_shift != 0 && calc_new(m_shadow, int'(sweep_shift), sweep_negate) > LIMIT) begin
            exp_dis.push_back(e + 2);
            m_en = 1'b0;
        end
    endtask

    task automatic mdl_tick(input int e);
        int n;
        m_timer = m_timer - 1;
        if (m_timer <= 0) begin
            m_timer = reload_of(int'(sweep_period));
            if (m_en && sweep_period != 0) begin
                n = calc_new(m_shadow, int'(sweep_shift), sweep_negate);
                if (n > LIMIT) begin
                    exp_dis.push_back(e + 1);
                    m_en = 1'b0;
                end else if (sweep_shift != 0) begin
                    exp_ld.push_back(mk_ev(e + 2, n));
                    m_shadow = n;
                    if (calc_new(n, int'(sweep_shift), sweep_negate) > LIMIT) begin
                        exp_dis.push_back(e + 3);
                        m_en = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic setup(input int f, input int p, input int s, input bit n);
        freq_in      = FREQ_W'(f);
        sweep_period = PER_W'(p);
        sweep_shift  = 3'(s);
        sweep_negate = n;
        repeat (3) @(negedge clk);
        got_ld.delete(); got_dis.delete(); exp_ld.delete(); exp_dis.delete();
    endtask

    task automatic pulse_restart(output int e);
        e = cyc + 1;
        ch1_restart = 1'b1;
        @(negedge clk);
        ch1_restart = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_tick(input int gap, output int e);
        e = cyc + 1;
        sweep_tick = 1'b1;
        @(negedge clk);
        sweep_tick = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic test_reset();
        apu_reset = 1'b1; sweep_tick = 1'b0; ch1_restart = 1'b0;
        freq_in = '0; sweep_period = '0; sweep_negate = 1'b0; sweep_shift = 3'd0;
        repeat (3) @(negedge clk);
        checks++; if (acc_d !== 11'h000) begin errors++; $display("FAIL reset_acc_d got=%h exp=000", acc_d); end
        checks++; if (freq_load !== 1'b0) begin errors++; $display("FAIL reset_freq_load got=%b exp=0", freq_load); end
        checks++; if (ch1_disable !== 1'b0) begin errors++; $display("FAIL reset_disable got=%b exp=0", ch1_disable); end
        checks++; if (sweep_en !== 1'b0) begin errors++; $display("FAIL reset_sweep_en got=%b exp=0", sweep_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        apu_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_add();
        int r, t;
        setup(12'h100, 1, 1, 1'b0);
        pulse_restart(r);
        checks++; if (sweep_en !== 1'b1) begin errors++; $display("FAIL basic_sweep_en got=%b exp=1", sweep_en); end
        pulse_tick(0, t);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_calc got=%b exp=1", busy); end
        repeat (5) @(negedge clk);
        checks++;
        if (got_ld.size() != 1 || ld_at(0) !== mk_ev(t + 2, 'h180)) begin
            errors++; $display("FAIL basic_load n=%0d got=%h exp=%h", got_ld.size(), ld_at(0), mk_ev(t + 2, 'h180));
        end
        checks++; if (got_dis.size() != 0) begin errors++; $display("FAIL basic_no_disable got=%0d exp=0", got_dis.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_idle got=%b exp=0", busy); end
    endtask

    task automatic test_overflow_trigger();
        int r, t;
        setup(12'h700, 1, 1, 1'b0);
        pulse_restart(r);
        checks++;
        if (got_dis.size() != 1 || got_dis[0] != r + 2) begin
            errors++; $display("FAIL ovf_trig_disable n=%0d exp_cyc=%0d", got_dis.size(), r + 2);
        end
        checks++; if (sweep_en !== 1'b0) begin errors++; $display("FAIL ovf_trig_sweep_en got=%b exp=0", sweep_en); end
        repeat (3) pulse_tick(4, t);
        checks++; if (got_ld.size() != 0) begin errors++; $display("FAIL ovf_trig_no_load got=%0d exp=0", got_ld.size()); end
    endtask

    task automatic test_negate();
        int r, t1, t2, t3, t4;
        setup(12'h400, 2, 2, 1'b1);
        pulse_restart(r);
        pulse_tick(4, t1);
        checks++; if (got_ld.size() != 0) begin errors++; $display("FAIL neg_first_tick got=%0d exp=0", got_ld.size()); end
        pulse_tick(4, t2);
        pulse_tick(4, t3);
        pulse_tick(4, t4);
        checks++;
        if (got_ld.size() != 2 || ld_at(0) !== mk_ev(t2 + 2, 'h300)) begin
            errors++; $display("FAIL neg_load0 n=%0d got=%h exp=%h", got_ld.size(), ld_at(0), mk_ev(t2 + 2, 'h300));
        end
        checks++;
        if (ld_at(1) !== mk_ev(t4 + 2, 'h240)) begin
            errors++; $display("FAIL neg_load1 got=%h exp=%h", ld_at(1), mk_ev(t4 + 2, 'h240));
        end
        checks++; if (got_dis.size() != 0) begin errors++; $display("FAIL neg_no_disable got=%0d exp=0", got_dis.size()); end
    endtask

    task automatic test_period_zero();
        int r, t;
        setup($urandom_range(0, 2047), 0, 0, 1'b0);
        pulse_restart(r);
        checks++; if (sweep_en !== 1'b0) begin errors++; $display("FAIL p0s0_sweep_en got=%b exp=0", sweep_en); end
        repeat (20) pulse_tick(3, t);
        checks++;
        if (got_ld.size() != 0 || got_dis.size() != 0) begin
            errors++; $display("FAIL p0s0_quiet loads=%0d disables=%0d exp=0/0", got_ld.size(), got_dis.size());
        end
        setup(12'h200, 0, 1, 1'b0);
        pulse_restart(r);
        checks++; if (sweep_en !== 1'b1) begin errors++; $display("FAIL p0s1_sweep_en got=%b exp=1", sweep_en); end
        repeat (20) pulse_tick(3, t);
        checks++;
        if (got_ld.size() != 0 || got_dis.size() != 0) begin
            errors++; $display("FAIL p0s1_quiet loads=%0d disables=%0d exp=0/0", got_ld.size(), got_dis.size());
        end
        checks++; if (sweep_en !== 1'b1) begin errors++; $display("FAIL p0s1_sweep_en_kept got=%b exp=1", sweep_en); end
    endtask

    task automatic test_collision();
        int r, t;
        setup(12'h100, 1, 1, 1'b0);
        pulse_restart(r);
        freq_in = 11'h080;
        sweep_tick = 1'b1; ch1_restart = 1'b1;
        @(negedge clk);
        sweep_tick = 1'b0; ch1_restart = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (got_ld.size() != 0) begin errors++; $display("FAIL collide_no_load got=%0d exp=0", got_ld.size()); end
        pulse_tick(5, t);
        checks++;
        if (got_ld.size() != 1 || ld_at(0) !== mk_ev(t + 2, 'h0C0)) begin
            errors++; $display("FAIL collide_load n=%0d got=%h exp=%h", got_ld.size(), ld_at(0), mk_ev(t + 2, 'h0C0));
        end
    endtask

    task automatic test_abort_write();
        int r, t;
        setup(12'h100, 1, 1, 1'b0);
        pulse_restart(r);
        pulse_tick(0, t);
        @(negedge clk);
        freq_in = 11'h050;
        ch1_restart = 1'b1;
        @(negedge clk);
        ch1_restart = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (got_ld.size() != 0 || got_dis.size() != 0) begin
            errors++; $display("FAIL abort_quiet loads=%0d disables=%0d exp=0/0", got_ld.size(), got_dis.size());
        end
        pulse_tick(5, t);
        checks++;
        if (got_ld.size() != 1 || ld_at(0) !== mk_ev(t + 2, 'h078)) begin
            errors++; $display("FAIL abort_shadow n=%0d got=%h exp=%h", got_ld.size(), ld_at(0), mk_ev(t + 2, 'h078));
        end
    endtask

    task automatic test_reset_in_write();
        int r, t;
        setup(12'h100, 1, 1, 1'b0);
        pulse_restart(r);
        pulse_tick(4, t);
        checks++; if (acc_d !== 11'h180) begin errors++; $display("FAIL rstw_pre_acc got=%h exp=180", acc_d); end
        pulse_tick(0, t);
        @(negedge clk);
        apu_reset = 1'b1;
        @(negedge clk);
        checks++; if (acc_d !== 11'h000) begin errors++; $display("FAIL rstw_acc_d got=%h exp=000", acc_d); end
        checks++; if (freq_load !== 1'b0) begin errors++; $display("FAIL rstw_freq_load got=%b exp=0", freq_load); end
        checks++; if (ch1_disable !== 1'b0) begin errors++; $display("FAIL rstw_disable got=%b exp=0", ch1_disable); end
        checks++; if (sweep_en !== 1'b0) begin errors++; $display("FAIL rstw_sweep_en got=%b exp=0", sweep_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw_busy got=%b exp=0", busy); end
        apu_reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (got_ld.size() != 1) begin errors++; $display("FAIL rstw_load_count got=%0d exp=1", got_ld.size()); end
    endtask

    task automatic test_negate_clear();
        int r, t, e;
        setup(12'h400, 1, 2, 1'b1);
        pulse_restart(r);
        pulse_tick(4, t);
        e = cyc + 1;
        sweep_negate = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (got_ld.size() != 1 || ld_at(0) !== mk_ev(t + 2, 'h300)) begin
            errors++; $display("FAIL negclr_load n=%0d got=%h exp=%h", got_ld.size(), ld_at(0), mk_ev(t + 2, 'h300));
        end
`ifdef CH1_SWEEP_NEG_QUIRK_EN
        checks++;
        if (got_dis.size() != 1 || got_dis[0] != e) begin
            errors++; $display("FAIL negclr_disable n=%0d exp_cyc=%0d", got_dis.size(), e);
        end
        checks++; if (sweep_en !== 1'b0) begin errors++; $display("FAIL negclr_sweep_en got=%b exp=0", sweep_en); end
`else
        checks++; if (got_dis.size() != 0) begin errors++; $display("FAIL negclr_no_disable got=%0d exp=0 (cyc %0d)", got_dis.size(), e); end
        checks++; if (sweep_en !== 1'b1) begin errors++; $display("FAIL negclr_sweep_en got=%b exp=1", sweep_en); end
`endif
    endtask

    task automatic test_random();
        int r, t, nt;
        for (int it = 0; it < 10; it++) begin
            setup($urandom_range(0, 2047), $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
            pulse_restart(r);
            mdl_restart(r);
            nt = $urandom_range(4, 12);
            for (int k = 0; k < nt; k++) begin
                pulse_tick($urandom_range(3, 6), t);
                mdl_tick(t);
            end
            repeat (4) @(negedge clk);
            checks++;
            if (got_ld.size() != exp_ld.size()) begin
                errors++; $display("FAIL rand%0d_load_count got=%0d exp=%0d", it, got_ld.size(), exp_ld.size());
            end
            for (int i = 0; i < exp_ld.size() && i < got_ld.size(); i++) begin
                checks++;
                if (got_ld[i] !== exp_ld[i]) begin
                    errors++; $display("FAIL rand%0d_load%0d got=%h exp=%h", it, i, got_ld[i], exp_ld[i]);
                end
            end
            checks++;
            if (got_dis.size() != exp_dis.size()) begin
                errors++; $display("FAIL rand%0d_disable_count got=%0d exp=%0d", it, got_dis.size(), exp_dis.size());
            end
            for (int i = 0; i < exp_dis.size() && i < got_dis.size(); i++) begin
                checks++;
                if (got_dis[i] != exp_dis[i]) begin
                    errors++; $display("FAIL rand%0d_disable%0d got=%0d exp=%0d", it, i, got_dis[i], exp_dis[i]);
                end
            end
            checks++;
            if (sweep_en !== m_en) begin
                errors++; $display("FAIL rand%0d_sweep_en got=%b exp=%b", it, sweep_en, m_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_overflow_trigger();
        test_negate();
        test_period_zero();
        test_collision();
        test_abort_write();
        test_reset_in_write();
        test_negate_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
